mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
Round-robin arbiter that shares one W-bit 2:1 select path between two requesters (A, B).
- Grants ownership by req/gnt handshake and drives the mux select.
- Registers the selected data with a valid flag.
- Bounds each ownership to MAX_HOLD cycles when the other side is waiting.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
W, 8, data width of each requester and of data_out
MAX_HOLD, 4, max consecutive owned cycles while the other requester waits (legal range 1..255)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
req_a  input  1  requester A wants the path (level, held while needed)
req_b  input  1  requester B wants the path
data_a  input  W  requester A data
data_b  input  W  requester B data
gnt_a  output  1  A owns the path this cycle
gnt_b  output  1  B owns the path this cycle
sel  output  1  mux select: 0=A, 1=B
data_out  output  W  registered selected data
valid_out  output  1  data_out holds owner data
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-low; clock is clk, reset is rst_n.
- Reset values (rst_n=0 at a clk edge):
  - state=IDLE; gnt_a=gnt_b=0; sel=0; data_out=0; valid_out=0; busy=0; hold_cnt=0.
  - last_owner=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B); both are registered via state and never high together.
- sel: 1 in OWN_B, 0 in OWN_A. In IDLE it holds its last value (no toggle while idle).
- IDLE transitions:
  - req_a&req_b -> grant the requester that is not last_owner.
  - req_a only -> OWN_A; req_b only -> OWN_B; none -> stay.
- OWN_A transitions (OWN_B is symmetric):
  - req_a=0 & req_b=1 -> OWN_B, with no idle gap.
  - req_a=0 & req_b=0 -> IDLE.
  - req_a=1 & req_b=1 & hold_cnt==MAX_HOLD-1 -> OWN_B (preemption).
  - Otherwise stay.
- Grant latency: gnt rises on the first clk edge sampling req=1 while the path is available.
- hold_cnt:
  - Clears on every entry to OWN_x and in IDLE.
  - Increments each owned cycle, saturating at MAX_HOLD-1.
  - Saturation without a contender has no effect.
  - MAX_HOLD=1: strict alternation under contention.
- last_owner updates on every entry to OWN_x.
- Datapath:
  - data_out <= gnt_a ? data_a : data_b whenever gnt_a|gnt_b; otherwise it holds.
  - valid_out <= gnt_a|gnt_b.
  - Data latency is 1 cycle after the grant cycle.
- Boundary cases:
  - Req dropped in the same cycle preemption fires: go to the other side (same as a release).
  - Reset mid-ownership: everything returns to reset values on that edge. The valid_out in flight is cleared.
  - Requester must keep req high to retain ownership; gnt is not sticky.

Optional Feature:
MUX_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt_a and grant_cnt_b, each 16 bits, saturating at 16'hFFFF.
  - Each increments on every entry to OWN_A / OWN_B respectively.
  - Both are cleared by rst_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mux_arb_pkg holds:
  - State encoding constants: IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10.
  - HOLD_CW = clog2 of MAX_HOLD, minimum 1.
  - STAT_W=16.
- One sub-module, mux_arb_hold_cnt: a clear/increment/saturate counter with a terminal flag (hold_cnt==MAX_HOLD-1). The FSM and datapath stay in the top.

Test Plan:
- Reset: hold rst_n=0 with req_a=req_b=1 -> all outputs 0, sel=0. Release reset -> gnt_a=1 on the next edge; valid_out=1 and data_out=data_a one cycle later.
- Single A: req_a high 10 cycles, data_a=8'h5A -> gnt_a held 10 cycles, no preemption, data_out=8'h5A. Drop req_a -> IDLE next edge, valid_out=0 one cycle later.
- Contention (MAX_HOLD=4): req_a=req_b=1 continuously -> gnt_a 4 cycles, gnt_b 4 cycles, alternating. sel toggles every 4 cycles; gnt_a&gnt_b never both 1.
- Release handover: OWN_A, req_b=1, req_a drops at hold_cnt=1 -> gnt_b on the next edge with no idle cycle; data_out switches to data_b one cycle later.
- Reset mid-ownership: in OWN_B at hold_cnt=2, pulse rst_n=0 one cycle -> gnt_b=0, valid_out=0, sel=0. With both requesting afterwards, A wins.
- MUX_ARB_STATS_EN defined: 3 grants A and 2 grants B -> grant_cnt_a=3, grant_cnt_b=2. Force counters near 16'hFFFF -> they saturate and do not wrap.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  localparam int unsigned STAT_W = 16;

  // Width of a counter holding 0..max_hold-1, never narrower than one bit.
  function automatic int unsigned hold_cw(input int unsigned max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Ownership-length counter: clear, saturating increment, terminal flag at MAX_HOLD-1.
module mux_arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CW       = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [CW-1:0] TERM = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a registered 2:1 data path between requesters A and B.
// Optional grant statistics outputs are enabled with `define MUX_ARB_STATS_EN.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] data_out,
  output logic         valid_out,
`ifdef MUX_ARB_STATS_EN
  output logic         busy,
  output logic [STAT_W-1:0] grant_cnt_a,
  output logic [STAT_W-1:0] grant_cnt_b
`else
  output logic         busy
`endif
);

  localparam int unsigned HOLD_CW = hold_cw(MAX_HOLD);

  state_e       state_q, state_d;
  logic         last_b_q, last_b_d;
  logic         sel_q, sel_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         hold_term;
  logic         enter_a, enter_b;
  logic         hold_clr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        // A release with B waiting hands over directly, same as a preemption.
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
        end else if (req_b && hold_term) begin
          state_d = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
        end else if (req_a && hold_term) begin
          state_d = OWN_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_a  = (state_d == OWN_A) && (state_q != OWN_A);
  assign enter_b  = (state_d == OWN_B) && (state_q != OWN_B);
  assign hold_clr = enter_a || enter_b || (state_d == IDLE);

  always_comb begin
    last_b_d = last_b_q;
    if (enter_a) begin
      last_b_d = 1'b0;
    end else if (enter_b) begin
      last_b_d = 1'b1;
    end

    sel_d = sel_q;
    if (state_d == OWN_A) begin
      sel_d = 1'b0;
    end else if (state_d == OWN_B) begin
      sel_d = 1'b1;
    end

    data_d  = data_q;
    valid_d = gnt_a || gnt_b;
    if (gnt_a) begin
      data_d = data_a;
    end else if (gnt_b) begin
      data_d = data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      sel_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  mux_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (HOLD_CW)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (hold_clr),
    .inc_i  (!hold_clr),
    .term_o (hold_term)
  );

  assign gnt_a     = (state_q == OWN_A);
  assign gnt_b     = (state_q == OWN_B);
  assign sel       = sel_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != IDLE);

`ifdef MUX_ARB_STATS_EN
  logic [STAT_W-1:0] gcnt_a_q, gcnt_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt_a_q <= '0;
      gcnt_b_q <= '0;
    end else begin
      if (enter_a && (gcnt_a_q != '1)) begin
        gcnt_a_q <= gcnt_a_q + STAT_W'(1);
      end
      if (enter_b && (gcnt_b_q != '1)) begin
        gcnt_b_q <= gcnt_b_q + STAT_W'(1);
      end
    end
  end

  assign grant_cnt_a = gcnt_a_q;
  assign grant_cnt_b = gcnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter (W=8, MAX_HOLD=4).
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, sel, valid_out, busy;
  logic [7:0] data_out;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_a       (req_a),
    .req_b       (req_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .sel         (sel),
    .data_out    (data_out),
    .valid_out   (valid_out),
`ifdef MUX_ARB_STATS_EN
    .busy        (busy),
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
`else
    .busy        (busy)
`endif
  );

  typedef struct packed {
    logic       rst_n;
    logic       ra;
    logic       rb;
    logic [7:0] da;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       sel;
    logic       vo;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic b);
    rst_n = r;
    req_a = a;
    req_b = b;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    data_a = 8'h00;
    data_b = 8'h00;

    //            rst ra  rb  da     db     ga  gb  sel vo  dout
    tbl[0]  = '{1'b0,1'b1,1'b1,8'h11,8'h22,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[1]  = '{1'b0,1'b1,1'b1,8'h11,8'h22,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[2]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b0,8'h00};
    tbl[3]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[4]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[5]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[6]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b0,1'b1,1'b1,1'b1,8'h11};
    tbl[7]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b0,1'b1,1'b1,1'b1,8'h22};
    tbl[8]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b0,1'b1,1'b1,1'b1,8'h22};
    tbl[9]  = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b0,1'b1,1'b1,1'b1,8'h22};
    tbl[10] = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b1,8'h22};
    tbl[11] = '{1'b1,1'b1,1'b1,8'h11,8'h22,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[12] = '{1'b1,1'b0,1'b1,8'h11,8'h22,1'b0,1'b1,1'b1,1'b1,8'h11};
    tbl[13] = '{1'b1,1'b0,1'b1,8'h11,8'h33,1'b0,1'b1,1'b1,1'b1,8'h33};
    tbl[14] = '{1'b1,1'b0,1'b0,8'h11,8'h33,1'b0,1'b0,1'b1,1'b1,8'h33};
    tbl[15] = '{1'b1,1'b0,1'b0,8'h11,8'h33,1'b0,1'b0,1'b1,1'b0,8'h33};
    tbl[16] = '{1'b1,1'b1,1'b0,8'h5A,8'h33,1'b1,1'b0,1'b0,1'b0,8'h33};
    tbl[17] = '{1'b1,1'b0,1'b0,8'h5A,8'h33,1'b0,1'b0,1'b0,1'b1,8'h5A};
    tbl[18] = '{1'b1,1'b1,1'b1,8'h5A,8'h33,1'b0,1'b1,1'b1,1'b0,8'h5A};
    tbl[19] = '{1'b1,1'b1,1'b1,8'h5A,8'h33,1'b0,1'b1,1'b1,1'b1,8'h33};
    tbl[20] = '{1'b1,1'b0,1'b0,8'h5A,8'h33,1'b0,1'b0,1'b1,1'b1,8'h33};

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst_n, tbl[i].ra, tbl[i].rb);
      data_a = tbl[i].da;
      data_b = tbl[i].db;
      step();
      check($sformatf("v%0d.gnt_a", i), 32'(gnt_a), 32'(tbl[i].ga));
      check($sformatf("v%0d.gnt_b", i), 32'(gnt_b), 32'(tbl[i].gb));
      check($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
      check($sformatf("v%0d.valid", i), 32'(valid_out), 32'(tbl[i].vo));
      check($sformatf("v%0d.data", i), 32'(data_out), 32'(tbl[i].dout));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].ga | tbl[i].gb));
    end

    // Single requester A held for 10 cycles: never preempted.
    do_reset();
    data_a = 8'h5A;
    data_b = 8'hC3;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("singleA%0d.gnt_a", i), 32'(gnt_a), 32'd1);
      check($sformatf("singleA%0d.gnt_b", i), 32'(gnt_b), 32'd0);
      if (i > 0) begin
        check($sformatf("singleA%0d.data", i), 32'(data_out), 32'h5A);
        check($sformatf("singleA%0d.valid", i), 32'(valid_out), 32'd1);
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    step();
    check("singleA_drop.gnt_a", 32'(gnt_a), 32'd0);
    check("singleA_drop.busy", 32'(busy), 32'd0);
    check("singleA_drop.valid", 32'(valid_out), 32'd1);
    step();
    check("singleA_idle.valid", 32'(valid_out), 32'd0);
    check("singleA_idle.data", 32'(data_out), 32'h5A);

    // Continuous contention: 4 cycles each, strictly alternating, A first.
    do_reset();
    data_a = 8'hA1;
    data_b = 8'hB2;
    drive(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 24; n++) begin
      logic exp_a;
      exp_a = ((n / 4) % 2) == 0;
      step();
      check($sformatf("cont%0d.gnt_a", n), 32'(gnt_a), 32'(exp_a));
      check($sformatf("cont%0d.gnt_b", n), 32'(gnt_b), 32'(!exp_a));
      check($sformatf("cont%0d.sel", n), 32'(sel), 32'(!exp_a));
    end

    // Reset mid-ownership of B (hold count 2), then A wins the next tie.
    do_reset();
    data_b = 8'h77;
    drive(1'b1, 1'b0, 1'b1);
    step();
    step();
    step();
    check("midrst_pre.gnt_b", 32'(gnt_b), 32'd1);
    check("midrst_pre.valid", 32'(valid_out), 32'd1);
    drive(1'b0, 1'b1, 1'b1);
    step();
    check("midrst.gnt_b", 32'(gnt_b), 32'd0);
    check("midrst.valid", 32'(valid_out), 32'd0);
    check("midrst.sel", 32'(sel), 32'd0);
    check("midrst.data", 32'(data_out), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b1, 1'b1);
    step();
    check("midrst_after.gnt_a", 32'(gnt_a), 32'd1);
    check("midrst_after.gnt_b", 32'(gnt_b), 32'd0);

`ifdef MUX_ARB_STATS_EN
    do_reset();
    check("stats_rst.a", 32'(grant_cnt_a), 32'd0);
    check("stats_rst.b", 32'(grant_cnt_b), 32'd0);
    for (int g = 0; g < 5; g++) begin
      if (g % 2 == 0) drive(1'b1, 1'b1, 1'b0);
      else            drive(1'b1, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b0, 1'b0);
      step();
    end
    check("stats.a", 32'(grant_cnt_a), 32'd3);
    check("stats.b", 32'(grant_cnt_b), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
